// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with programmable wait states,
// two-cycle ERROR response for illegal size/alignment, and write-to-read forwarding.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int WSM1  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [31:0]           hrdata_q, hrdata_d;

    logic [31:0]           mem [DEPTH];

    logic                  accept, legal, wr_en, rd_load;
    logic [3:0]            be;
    logic [ADDR_WIDTH-3:0] raddr;
    logic [31:0]           rword;
    logic                  unused_bits;

    assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};

    assign hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = hrdata_q;

    // Gating on our own ready keeps a stalled data phase from re-capturing.
    assign accept = hsel & hready & htrans[1] & hreadyout;

    always_comb begin
        legal = 1'b0;
        case (hsize)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~haddr[0];
            3'b010:  legal = (haddr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        case (size_q)
            3'b000:  be = 4'b0001 << addr_q[1:0];
            3'b001:  be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // A legal transfer completes in the cycle where it is pending and the FSM sits in IDLE.
    assign wr_en = pend_q & write_q & (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
                if (accept) begin
                    if (legal) begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WSM1);
                        end
                    end else begin
                        state_d = S_ERR1;
                    end
                end
            end
        endcase
    end

    // Read data is loaded at the edge that starts the completing cycle.
    assign rd_load = (accept & legal & ~hwrite & (WAIT_STATES == 0)) |
                     ((state_q == S_WAIT) & (cnt_q == 4'd0) & ~write_q);
    assign raddr   = (state_q == S_WAIT) ? addr_q[ADDR_WIDTH-1:2] : haddr[ADDR_WIDTH-1:2];

    always_comb begin
        rword = mem[raddr];
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i] && (addr_q[ADDR_WIDTH-1:2] == raddr))
                rword[8*i +: 8] = hwdata[8*i +: 8];
        end
        hrdata_d = rd_load ? rword : hrdata_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'b000;
            hrdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            hrdata_q <= hrdata_d;
            if (accept) begin
                addr_q  <= haddr[ADDR_WIDTH-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with no wait states, one with a single wait
// state; a negedge monitor pops queued expectations as each data phase runs.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic        block = 1'b0;
    logic [1:0]  hro, hrs, hrdy;
    logic [31:0] hrd0, hrd1;

    always #5 hclk = ~hclk;

    // Global hready as the master-side mux would return it; block models another slave stalling.
    assign hrdy = hro & ~{2{block}};

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hrdy[0]),
        .hreadyout(hro[0]), .hresp(hrs[0]), .hrdata(hrd0));

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(sel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hrdy[1]),
        .hreadyout(hro[1]), .hresp(hrs[1]), .hrdata(hrd1));

    typedef struct {
        int          k;
        bit          wr;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          k;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    exp_t cur[2];
    int   lat[2];
    bit [1:0] dph = 2'b00;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] rd_of(int k);
        return (k == 0) ? hrd0 : hrd1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge hclk) begin
        if (!hresetn) dph = 2'b00;
        else if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (dph[k]) begin
                    lat[k]++;
                    check($sformatf("hresp_dut%0d", k), 32'(hrs[k]), 32'(cur[k].err));
                    if (hro[k]) begin
                        check($sformatf("latency_dut%0d", k), 32'(lat[k]), 32'(cur[k].lat));
                        if (cur[k].chk) check($sformatf("hrdata_dut%0d", k), rd_of(k), cur[k].rdata);
                        dph[k] = 1'b0;
                    end
                end else begin
                    check($sformatf("idle_hreadyout_dut%0d", k), 32'(hro[k]), 32'd1);
                    check($sformatf("idle_hresp_dut%0d", k), 32'(hrs[k]), 32'd0);
                end
                if (hrdy[k] && sel[k] && htrans[1]) begin
                    if (sbq.size() == 0 || sbq[0].k != k) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept dut%0d actual=accept required=none", k);
                    end else begin
                        cur[k] = sbq.pop_front();
                        dph[k] = 1'b1;
                        lat[k] = 0;
                    end
                end
            end
        end
    end

    task automatic add(int k, bit wr, logic [11:0] a, logic [2:0] s, logic [31:0] wd,
                       bit err, logic [31:0] rd);
        vec_t v;
        v.k = k; v.wr = wr; v.addr = a; v.size = s; v.wdata = wd; v.err = err; v.rdata = rd;
        tbl.push_back(v);
    endtask

    task automatic wait_ready(int k);
        int n = 0;
        @(negedge hclk);
        while (!hrdy[k] && n < 50) begin
            @(negedge hclk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d actual=hready_low required=hready_high", k);
        end
    endtask

    // Drives an address phase, waits for acceptance, then presents write data.
    task automatic issue(vec_t v);
        exp_t e;
        sel    = (v.k == 0) ? 2'b01 : 2'b10;
        haddr  = {20'h0, v.addr};
        hwrite = v.wr;
        hsize  = v.size;
        htrans = 2'b10;
        e.k     = v.k;
        e.err   = v.err;
        e.chk   = !v.wr && !v.err;
        e.rdata = v.rdata;
        e.lat   = v.err ? 2 : ((v.k == 0) ? 1 : 2);
        sbq.push_back(e);
        wait_ready(v.k);
        @(posedge hclk);
        #1;
        if (v.wr) hwdata = v.wdata;
    endtask

    task automatic idle_done(int k);
        sel    = 2'b00;
        htrans = 2'b00;
        wait_ready(k);
        @(posedge hclk);
        #1;
    endtask

    task automatic one(int k, bit wr, logic [11:0] a, logic [31:0] wd, logic [31:0] rd);
        vec_t v;
        v.k = k; v.wr = wr; v.addr = a; v.size = 3'b010; v.wdata = wd; v.err = 1'b0; v.rdata = rd;
        issue(v);
        idle_done(k);
    endtask

    initial begin
        // One-wait-state instance: byte/half merges, error responses, pipelined accepts.
        add(1, 1, 12'h000, 3'b010, 32'h0BADF00D, 0, 32'h0);
        add(1, 1, 12'h010, 3'b010, 32'hDEADBEEF, 0, 32'h0);
        add(1, 0, 12'h010, 3'b010, 32'h0,        0, 32'hDEADBEEF);
        add(1, 1, 12'h010, 3'b010, 32'h11223344, 0, 32'h0);
        add(1, 1, 12'h013, 3'b000, 32'hAA000000, 0, 32'h0);
        add(1, 0, 12'h010, 3'b010, 32'h0,        0, 32'hAA223344);
        add(1, 1, 12'h012, 3'b001, 32'h55660000, 0, 32'h0);
        add(1, 0, 12'h010, 3'b010, 32'h0,        0, 32'h55663344);
        add(1, 0, 12'h011, 3'b000, 32'h0,        0, 32'h55663344);
        add(1, 1, 12'h002, 3'b010, 32'hFFFFFFFF, 1, 32'h0);
        add(1, 0, 12'h000, 3'b011, 32'h0,        1, 32'h0);
        add(1, 1, 12'h001, 3'b001, 32'hFFFFFFFF, 1, 32'h0);
        add(1, 0, 12'h000, 3'b010, 32'h0,        0, 32'h0BADF00D);
        add(1, 0, 12'h010, 3'b010, 32'h0,        0, 32'h55663344);
        // Zero-wait-state instance: back-to-back write then read of the same word.
        add(0, 1, 12'h020, 3'b010, 32'h12345678, 0, 32'h0);
        add(0, 0, 12'h020, 3'b010, 32'h0,        0, 32'h12345678);
        add(0, 1, 12'h021, 3'b000, 32'h0000AB00, 0, 32'h0);
        add(0, 0, 12'h020, 3'b010, 32'h0,        0, 32'h1234AB78);
        add(0, 1, 12'h024, 3'b010, 32'h00000000, 0, 32'h0);
        add(0, 1, 12'h026, 3'b001, 32'hBEEF0000, 0, 32'h0);
        add(0, 0, 12'h024, 3'b010, 32'h0,        0, 32'hBEEF0000);
        add(0, 0, 12'h022, 3'b010, 32'h0,        1, 32'h0);
        add(0, 0, 12'h020, 3'b010, 32'h0,        0, 32'h1234AB78);

        repeat (3) @(posedge hclk);
        #1;
        check("reset_hreadyout_ws0", 32'(hro[0]), 32'd1);
        check("reset_hreadyout_ws1", 32'(hro[1]), 32'd1);
        check("reset_hresp_ws0", 32'(hrs[0]), 32'd0);
        check("reset_hresp_ws1", 32'(hrs[1]), 32'd0);
        check("reset_hrdata_ws0", hrd0, 32'h0);
        check("reset_hrdata_ws1", hrd1, 32'h0);
        hresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge hclk);
        #1;

        for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);
        idle_done(0);
        idle_done(1);

        // No-transfer cycles: IDLE, BUSY, deselected NONSEQ, then NONSEQ stalled by another slave.
        hwdata = 32'h0;
        haddr  = 32'h010;
        hwrite = 1'b1;
        hsize  = 3'b010;
        sel = 2'b10; htrans = 2'b00;
        repeat (2) @(posedge hclk);
        #1 htrans = 2'b01;
        repeat (2) @(posedge hclk);
        #1 sel = 2'b00; htrans = 2'b10;
        repeat (2) @(posedge hclk);
        #1 sel = 2'b10; block = 1'b1;
        repeat (3) @(posedge hclk);
        #1 sel = 2'b00; htrans = 2'b00; block = 1'b0;
        @(posedge hclk);
        #1;
        one(1, 0, 12'h010, 32'h0, 32'h55663344);

        // Reset during the wait cycle of a write discards it.
        one(1, 1, 12'h030, 32'h01020304, 32'h0);
        mon_en = 1'b0;
        sel = 2'b10; haddr = 32'h030; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        @(posedge hclk);
        #1;
        hwdata = 32'hCAFEF00D;
        sel    = 2'b00;
        htrans = 2'b00;
        check("wait_hreadyout", 32'(hro[1]), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        check("rst_hreadyout", 32'(hro[1]), 32'd1);
        check("rst_hresp", 32'(hrs[1]), 32'd0);
        check("rst_hrdata", hrd1, 32'h0);
        @(posedge hclk);
        #1 hresetn = 1'b1;
        mon_en = 1'b1;
        @(posedge hclk);
        #1;
        one(1, 0, 12'h030, 32'h0, 32'h01020304);

        repeat (2) @(posedge hclk);
        #1;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        check("data_phase_drained", 32'(dph), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
